// File: rtl/clk_div_bank_if.sv
// Divisor write port of clk_div_bank.
//   wr_en  : single-cycle write strobe
//   wr_ch  : target channel index
//   wr_div : new divisor (0 disables the channel)
//   wr_ack : one-cycle pulse, write accepted (valid channel)
//   wr_err : one-cycle pulse, write rejected (channel out of range)
// master drives the write; slave is the divider bank.
interface clk_div_bank_if #(
  parameter int unsigned W = 32
) ();
  logic         wr_en;
  logic [3:0]   wr_ch;
  logic [W-1:0] wr_div;
  logic         wr_ack;
  logic         wr_err;

  modport master (
    output wr_en, wr_ch, wr_div,
    input  wr_ack, wr_err
  );

  modport slave (
    input  wr_en, wr_ch, wr_div,
    output wr_ack, wr_err
  );
endinterface

// File: rtl/clk_div_bank.sv
// Runtime-programmable bank of CH clock dividers.
//   fpga_clk : system clock
//   rst      : asynchronous active-low reset
//   sync     : restarts every channel period, applies pending divisors
//   wr       : divisor write port (clk_div_bank_if slave)
//   o_clk    : divided clock per channel (high ceil(D/2), low floor(D/2))
//   tick     : one-cycle pulse in the last cycle of each period
//   pending  : channel holds a written divisor not yet applied
// All outputs are registered. New divisors take effect at the period
// boundary so no runt pulse is produced.
module clk_div_bank #(
  parameter int unsigned CH       = 4,
  parameter int unsigned W        = 32,
  parameter int unsigned INIT_DIV = 100
) (
  input  logic                 fpga_clk,
  input  logic                 rst,
  input  logic                 sync,
  clk_div_bank_if.slave        wr,
  output logic [CH-1:0]        o_clk,
  output logic [CH-1:0]        tick,
  output logic [CH-1:0]        pending
);

  logic [W-1:0] cnt      [CH];
  logic [W-1:0] div_act  [CH];
  logic [W-1:0] div_pend [CH];
  logic [CH-1:0] pend_vld;

  logic          wr_ok;
  logic [CH-1:0] wr_hit;
  logic [CH-1:0] last;
  logic [CH-1:0] high;

  always_comb begin
    wr_ok  = wr.wr_en && (32'(wr.wr_ch) < CH);
    wr_hit = '0;
    last   = '0;
    high   = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      wr_hit[i] = wr_ok && (wr.wr_ch == 4'(i));
      // last is only meaningful when div_act != 0
      last[i]   = (cnt[i] == div_act[i] - W'(1));
      // ceil(D/2) computed without overflowing at D = 2^W-1
      high[i]   = (cnt[i] < ((div_act[i] >> 1) + W'(div_act[i][0])));
    end
  end

  always_ff @(posedge fpga_clk or negedge rst) begin
    if (!rst) begin
      wr.wr_ack <= 1'b0;
      wr.wr_err <= 1'b0;
      o_clk     <= '0;
      tick      <= '0;
      pend_vld  <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        cnt[i]      <= '0;
        div_act[i]  <= W'(INIT_DIV);
        div_pend[i] <= '0;
      end
    end else begin
      wr.wr_ack <= wr_ok;
      wr.wr_err <= wr.wr_en && !wr_ok;
      for (int unsigned i = 0; i < CH; i++) begin
        if (sync) begin
          cnt[i]   <= '0;
          o_clk[i] <= 1'b0;
          tick[i]  <= 1'b0;
          // a write on the sync edge goes straight to the active divisor
          if (wr_hit[i]) begin
            div_act[i]  <= wr.wr_div;
            pend_vld[i] <= 1'b0;
          end else if (pend_vld[i]) begin
            div_act[i]  <= div_pend[i];
            pend_vld[i] <= 1'b0;
          end
        end else begin
          if (div_act[i] == '0) begin
            cnt[i]   <= '0;
            o_clk[i] <= 1'b0;
            tick[i]  <= 1'b0;
            if (pend_vld[i]) begin
              div_act[i]  <= div_pend[i];
              pend_vld[i] <= 1'b0;
            end
          end else begin
            o_clk[i] <= high[i];
            tick[i]  <= last[i];
            if (last[i]) begin
              cnt[i] <= '0;
              if (pend_vld[i]) begin
                div_act[i]  <= div_pend[i];
                pend_vld[i] <= 1'b0;
              end
            end else begin
              cnt[i] <= cnt[i] + W'(1);
            end
          end
          // placed last: a write landing on a boundary edge stays pending
          if (wr_hit[i]) begin
            div_pend[i] <= wr.wr_div;
            pend_vld[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign pending = pend_vld;

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;
  localparam int unsigned CH   = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned INIT = 4;

  typedef struct packed {
    logic [3:0] o;
    logic [3:0] t;
    logic [3:0] p;
    logic       a;
    logic       e;
  } exp_t;

  logic          fpga_clk = 1'b0;
  logic          rst      = 1'b0;
  logic          sync     = 1'b0;
  logic [CH-1:0] o_clk;
  logic [CH-1:0] tick;
  logic [CH-1:0] pending;

  clk_div_bank_if #(.W(W)) wr_if ();

  clk_div_bank #(.CH(CH), .W(W), .INIT_DIV(INIT)) dut (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .sync     (sync),
    .wr       (wr_if.slave),
    .o_clk    (o_clk),
    .tick     (tick),
    .pending  (pending)
  );

  always #5 fpga_clk = ~fpga_clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  // reference model state, spec-level formulation
  longint unsigned m_cnt  [CH];
  longint unsigned m_act  [CH];
  longint unsigned m_pend [CH];
  bit              m_pv   [CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c]  = 0;
      m_act[c]  = INIT;
      m_pend[c] = 0;
      m_pv[c]   = 1'b0;
    end
  endtask

  // Called just after a falling edge: drive inputs, predict the outputs of
  // the next rising edge, then compare them and return at the next falling edge.
  task automatic step(input logic s, input logic we, input logic [3:0] ch,
                      input logic [W-1:0] dv);
    exp_t e;
    exp_t g;
    bit   hit;
    sync         = s;
    wr_if.wr_en  = we;
    wr_if.wr_ch  = ch;
    wr_if.wr_div = dv;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      hit = we && (ch == 4'(c));
      if (s) begin
        m_cnt[c] = 0;
        if (hit) begin
          m_act[c] = dv; m_pv[c] = 1'b0;
        end else if (m_pv[c]) begin
          m_act[c] = m_pend[c]; m_pv[c] = 1'b0;
        end
      end else begin
        if (m_act[c] == 0) begin
          m_cnt[c] = 0;
          if (m_pv[c]) begin
            m_act[c] = m_pend[c]; m_pv[c] = 1'b0;
          end
        end else begin
          e.o[c] = (2 * m_cnt[c] < m_act[c]);
          e.t[c] = (m_cnt[c] + 1 == m_act[c]);
          if (e.t[c]) begin
            m_cnt[c] = 0;
            if (m_pv[c]) begin
              m_act[c] = m_pend[c]; m_pv[c] = 1'b0;
            end
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
          end
        end
        if (hit) begin
          m_pend[c] = dv; m_pv[c] = 1'b1;
        end
      end
      e.p[c] = m_pv[c];
    end
    e.a = we && (ch < 4'(CH));
    e.e = we && !(ch < 4'(CH));
    sb.push_back(e);
    @(posedge fpga_clk);
    #1;
    g = sb.pop_front();
    check("o_clk",   64'(o_clk),        64'(g.o));
    check("tick",    64'(tick),         64'(g.t));
    check("pending", 64'(pending),      64'(g.p));
    check("wr_ack",  64'(wr_if.wr_ack), 64'(g.a));
    check("wr_err",  64'(wr_if.wr_err), 64'(g.e));
    @(negedge fpga_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, '0);
  endtask

  task automatic wr(input logic [3:0] ch, input logic [W-1:0] dv);
    step(1'b0, 1'b1, ch, dv);
  endtask

  logic [7:0] pat_o;
  logic [7:0] pat_t;

  initial begin
    sync         = 1'b0;
    wr_if.wr_en  = 1'b0;
    wr_if.wr_ch  = '0;
    wr_if.wr_div = '0;
    model_reset();
    repeat (3) @(posedge fpga_clk);
    #1;
    check("rst_o_clk",   64'(o_clk),   64'(0));
    check("rst_tick",    64'(tick),    64'(0));
    check("rst_pending", 64'(pending), 64'(0));
    @(negedge fpga_clk);
    rst = 1'b1;

    // default divisor 4: 2 high / 2 low, tick in the second low cycle
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 4'd0, '0);
      pat_o[i] = o_clk[0];
      pat_t[i] = tick[0];
    end
    check("init_o_pattern", 64'(pat_o), 64'(8'b0011_0011));
    check("init_t_pattern", 64'(pat_t), 64'(8'b1000_1000));

    // mid-period divisor change on ch1
    idle(1);
    wr(4'd1, 32'd5);
    idle(20);

    // disable ch2, then re-enable with 6
    wr(4'd2, 32'd0);
    idle(10);
    wr(4'd2, 32'd6);
    idle(15);

    // out-of-range channel
    wr(4'd7, 32'd9);
    idle(3);

    // back-to-back writes, last wins
    wr(4'd1, 32'd9);
    wr(4'd1, 32'd3);
    wr(4'd2, 32'd4);
    wr(4'd3, 32'd7);
    wr(4'd0, 32'd11);
    idle(2);

    // sync with simultaneous ch0 write
    step(1'b1, 1'b1, 4'd0, 32'd2);
    check("sync_o_low", 64'(o_clk), 64'(0));
    idle(1);
    check("sync_o_high", 64'(o_clk), 64'(4'b1111));
    idle(20);

    // divisor 1: constant high, tick every cycle
    wr(4'd3, 32'd1);
    idle(10);
    check("d1_o", 64'(o_clk[3]), 64'(1));
    check("d1_t", 64'(tick[3]),  64'(1));
    idle(5);

    // asynchronous reset mid-run
    #2;
    rst = 1'b0;
    #1;
    check("arst_o_clk",   64'(o_clk),        64'(0));
    check("arst_tick",    64'(tick),         64'(0));
    check("arst_pending", 64'(pending),      64'(0));
    check("arst_wr_ack",  64'(wr_if.wr_ack), 64'(0));
    model_reset();
    @(negedge fpga_clk);
    rst = 1'b1;
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Runtime-programmable bank of CH independent clock dividers driven from the 100 MHz board clock, the successor to the fixed-ratio divider chain. Each channel produces a divided clock (near-50% duty) and a one-cycle period-end tick. Divisors are reloaded through a simple write port and take effect glitch-free at the channel's next period boundary. A global sync input phase-aligns all channels.

## Interface
- CH, 4, number of divider channels (1..16)
- W, 32, divisor and counter width in bits
- INIT_DIV, 100, divisor loaded into every channel at reset (must be < 2^W)
- fpga_clk  in  1  system clock (100 MHz)
- rst  in  1  reset, asynchronous, active-low
- sync  in  1  synchronous restart of all channel periods
- wr_en  in  1  divisor write strobe, single-cycle
- wr_ch  in  4  target channel index
- wr_div  in  W  new divisor; 0 disables the channel
- wr_ack  out  1  one-cycle pulse, write accepted
- wr_err  out  1  one-cycle pulse, write rejected (wr_ch >= CH)
- o_clk  out  CH  divided clock per channel
- tick  out  CH  one-cycle pulse in the last cycle of each period
- pending  out  CH  channel holds a written divisor not yet applied

## Operation
- Per channel state: cnt[W], div_act[W], div_pend[W], pend_vld.
- Reset (rst=0): cnt=0, div_act=INIT_DIV, pend_vld=0, all outputs 0.
- Write: on an edge with wr_en=1:
  - wr_ch < CH: div_pend <= wr_div, pend_vld <= 1, wr_ack=1 next cycle.
  - wr_ch >= CH: no state change, wr_err=1 next cycle.
  - A second write before the boundary overwrites div_pend; last write wins; each write is acked.
- Active channel (div_act != 0), each edge:
  - o_clk <= (cnt < ceil(div_act/2)); tick <= (cnt == div_act-1).
  - If cnt == div_act-1: cnt <= 0; if pend_vld: div_act <= div_pend, pend_vld <= 0.
  - Else cnt <= cnt+1.
  - High phase = ceil(D/2) cycles, low phase = floor(D/2). D=1: o_clk constant 1, tick every cycle.
- Disabled channel (div_act == 0): cnt <= 0, o_clk <= 0, tick <= 0; a pending divisor is applied on the next edge (no boundary to wait for).
- Writing 0 to an active channel disables it at its next boundary; o_clk is then 0 from that point.
- sync=1 on an edge: every channel cnt <= 0, o_clk <= 0, tick <= 0, pending divisors applied immediately (pend_vld <= 0). A write to a channel on the same edge as sync bypasses straight to div_act (write wins, wr_ack still issued, pending stays 0).
- pending output = pend_vld.
- Counters never exceed div_act-1; no wrap through 2^W.

## Timing
- All outputs registered on fpga_clk rising edge; no combinational input-to-output path.
- Outputs lag the internal cnt by one cycle: first o_clk high cycle is the cycle after the first edge following reset release.
- Write-to-ack latency: 1 cycle. wr_en may be asserted every cycle.
- Divisor change latency: applied at the edge ending the current period; the new period starts with its high phase, no runt pulse.
- Reset mid-period: asynchronous clear; outputs 0 immediately, restart from cnt=0 with INIT_DIV.
- Two channels with equal divisors after sync are cycle-identical.

## Test plan
- Reset, INIT_DIV=4, no writes -> every o_clk: 2 high / 2 low repeating, tick high in each 4th cycle coincident with second low cycle; pending=0.
- Write ch1 div=5 mid-period -> wr_ack 1 cycle later, pending[1]=1 until ch1 boundary; then 3 high / 2 low; channels 0,2,3 unchanged.
- Write ch2 div=0, then div=6 after 10 cycles -> ch2 goes low at boundary and stays 0 with tick=0; after second write, pending applied next edge, 3 high / 3 low.
- wr_ch=7 with CH=4 -> wr_err pulse, no wr_ack, no channel state change.
- Channels at div 3,4,7; assert sync with simultaneous write ch0 div=2 -> all o_clk 0 that cycle, next cycle all high; ch0 runs 1/1, others 2/1, 2/2, 4/3.
- Write div=1 ch3 -> after boundary o_clk[3] constant 1, tick[3] every cycle; assert rst low mid-run -> all outputs 0 immediately, resume at INIT_DIV.
